// File: rtl/instr_fetch.sv
// Byte-wide instruction fetcher: walks an 8-bit PC through a fixed-latency SRAM, hands
// bytes downstream over valid/ready, and vectors to INT_VECTOR on a synchronized interrupt edge.
module instr_fetch #(
  parameter int          MEM_LAT    = 1,
  parameter logic [7:0]  INT_VECTOR = 8'h3C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt,
  input  logic [7:0] mem_data,
  output logic [7:0] mem_addr,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       jump,
  input  logic [7:0] jump_addr,
  output logic       int_ack,
  output logic [7:0] ret_pc,
  output logic [7:0] pc
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    INTA = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] mem_addr_q;
  logic [7:0] instr_q;
  logic       instr_valid_q;
  logic       int_ack_q;
  logic [7:0] ret_pc_q;
  logic [1:0] cnt_q;
  logic       sync1_q;
  logic       sync2_q;
  logic       sync3_q;
  logic       int_pending_q;
  logic       int_pending_d;
  logic       int_rise;

  // A new edge wins over the INTA clear so an edge landing in INTA is not lost.
  assign int_rise      = sync2_q & ~sync3_q;
  assign int_pending_d = int_rise | (int_pending_q & (state_q != INTA));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= 8'h00;
      mem_addr_q    <= 8'h00;
      instr_q       <= 8'h00;
      instr_valid_q <= 1'b0;
      int_ack_q     <= 1'b0;
      ret_pc_q      <= 8'h00;
      cnt_q         <= 2'd0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      sync1_q       <= interrupt;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      int_pending_q <= int_pending_d;
      int_ack_q     <= 1'b0;
      case (state_q)
        IDLE: state_q <= ADDR;
        ADDR: begin
          mem_addr_q <= pc_q;
          cnt_q      <= 2'(MEM_LAT);
          state_q    <= WAIT;
        end
        // mem_addr is itself registered, so the byte is ready one cycle after the count runs out.
        WAIT: begin
          if (cnt_q == 2'd0) begin
            instr_q       <= mem_data;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + 8'd1;
            state_q       <= HOLD;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (jump) pc_q <= jump_addr;
            if (int_pending_q) begin
              int_ack_q <= 1'b1;
              state_q   <= INTA;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        INTA: begin
          ret_pc_q <= pc_q;
          pc_q     <= INT_VECTOR;
          state_q  <= ADDR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign int_ack     = int_ack_q;
  assign ret_pc      = ret_pc_q;
  assign pc          = pc_q;

endmodule
